// File: rtl/stage_id_buf_pkg.sv
// Shared constants and the decode bundle for the buffered decode stage.
package stage_id_buf_pkg;

   // Widths
   localparam int INST_W_DEF  = 32;
   localparam int INST_ADDR_W = 32;
   localparam int DATA_W_DEF  = 32;
   localparam int REG_ADDR_W  = 5;
   localparam int ALU_SRC_W   = 2;
   localparam int ALU_OP_W    = 4;

   // RV32I major opcodes
   localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
   localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
   localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
   localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
   localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
   localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
   localparam logic [6:0] OPCODE_ALUI   = 7'b0010011;
   localparam logic [6:0] OPCODE_ALUR   = 7'b0110011;

   // The only func7 values accepted for register-register ALU ops
   localparam logic [6:0] FUNC7_ALU_0 = 7'b0000000;
   localparam logic [6:0] FUNC7_ALU_1 = 7'b0100000;

   // ALU operation {func7[5], func3}; ADD is the all-zero encoding
   localparam logic [ALU_OP_W-1:0] ALU_OP_ADD = 4'b0000;

   // ALU operand selects
   localparam logic [ALU_SRC_W-1:0] ALU_SRC_R   = 2'd0;
   localparam logic [ALU_SRC_W-1:0] ALU_SRC_IMM = 2'd1;
   localparam logic [ALU_SRC_W-1:0] ALU_SRC_PC  = 2'd2;

   // Everything the execute stage needs from one instruction
   typedef struct packed {
      logic                  reg_wr;
      logic [REG_ADDR_W-1:0] rd;
      logic [REG_ADDR_W-1:0] rs1;
      logic [REG_ADDR_W-1:0] rs2;
      logic [ALU_OP_W-1:0]   alu_op;
      logic [ALU_SRC_W-1:0]  src1;
      logic [ALU_SRC_W-1:0]  src2;
      logic [31:0]           imm;
      logic                  is_jump;
      logic                  is_branch;
      logic                  is_load;
      logic                  is_store;
      logic                  illegal;
      logic [2:0]            branch_type;
      logic [2:0]            mem_size;
   } dec_t;

endpackage

// File: rtl/stage_id_buf_inst_decoder.sv
// Purely combinational RV32I integer decoder: instruction word in, decode bundle out.
// Unused register fields are forced to zero so the hazard logic sees no false dependencies.
module inst_decoder
   import stage_id_buf_pkg::*;
(
   input  logic [31:0] inst,
   output dec_t        dec
);

   logic [6:0]            opcode;
   logic [2:0]            func3;
   logic [6:0]            func7;
   logic [REG_ADDR_W-1:0] rd_f;
   logic [REG_ADDR_W-1:0] rs1_f;
   logic [REG_ADDR_W-1:0] rs2_f;
   logic [31:0]           imm_i;
   logic [31:0]           imm_s;
   logic [31:0]           imm_b;
   logic [31:0]           imm_u;
   logic [31:0]           imm_j;

   assign opcode = inst[6:0];
   assign func3  = inst[14:12];
   assign func7  = inst[31:25];
   assign rd_f   = inst[11:7];
   assign rs1_f  = inst[19:15];
   assign rs2_f  = inst[24:20];

   assign imm_i = {{20{inst[31]}}, inst[31:20]};
   assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
   assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
   assign imm_u = {inst[31:12], 12'b0};
   assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

   // Per-opcode field selection; anything unrecognised is flagged illegal with all else zero
   always_comb begin
      dec        = '0;
      dec.alu_op = ALU_OP_ADD;
      unique case (opcode)
         OPCODE_LUI: begin
            dec.rd     = rd_f;
            dec.reg_wr = (rd_f != '0);
            dec.src1   = ALU_SRC_R;
            dec.src2   = ALU_SRC_IMM;
            dec.imm    = imm_u;
         end
         OPCODE_AUIPC: begin
            dec.rd     = rd_f;
            dec.reg_wr = (rd_f != '0);
            dec.src1   = ALU_SRC_PC;
            dec.src2   = ALU_SRC_IMM;
            dec.imm    = imm_u;
         end
         OPCODE_JAL: begin
            dec.rd      = rd_f;
            dec.reg_wr  = (rd_f != '0);
            dec.src1    = ALU_SRC_PC;
            dec.src2    = ALU_SRC_IMM;
            dec.imm     = imm_j;
            dec.is_jump = 1'b1;
         end
         OPCODE_JALR: begin
            dec.rd      = rd_f;
            dec.reg_wr  = (rd_f != '0);
            dec.rs1     = rs1_f;
            dec.src1    = ALU_SRC_R;
            dec.src2    = ALU_SRC_IMM;
            dec.imm     = imm_i;
            dec.is_jump = 1'b1;
         end
         OPCODE_BRANCH: begin
            dec.rs1         = rs1_f;
            dec.rs2         = rs2_f;
            dec.src1        = ALU_SRC_PC;
            dec.src2        = ALU_SRC_IMM;
            dec.imm         = imm_b;
            dec.is_branch   = 1'b1;
            dec.branch_type = func3;
         end
         OPCODE_LOAD: begin
            dec.rd       = rd_f;
            dec.reg_wr   = (rd_f != '0);
            dec.rs1      = rs1_f;
            dec.src1     = ALU_SRC_R;
            dec.src2     = ALU_SRC_IMM;
            dec.imm      = imm_i;
            dec.is_load  = 1'b1;
            dec.mem_size = func3;
         end
         OPCODE_STORE: begin
            dec.rs1      = rs1_f;
            dec.rs2      = rs2_f;
            dec.src1     = ALU_SRC_R;
            dec.src2     = ALU_SRC_IMM;
            dec.imm      = imm_s;
            dec.is_store = 1'b1;
            dec.mem_size = func3;
         end
         OPCODE_ALUI: begin
            dec.rd     = rd_f;
            dec.reg_wr = (rd_f != '0);
            dec.rs1    = rs1_f;
            dec.src1   = ALU_SRC_R;
            dec.src2   = ALU_SRC_IMM;
            dec.imm    = imm_i;
            // Only the right shifts carry an arithmetic/logical selector in bit 30
            dec.alu_op = {(func3 == 3'b101) ? inst[30] : 1'b0, func3};
         end
         OPCODE_ALUR: begin
            if ((func7 == FUNC7_ALU_0) || (func7 == FUNC7_ALU_1)) begin
               dec.rd     = rd_f;
               dec.reg_wr = (rd_f != '0);
               dec.rs1    = rs1_f;
               dec.rs2    = rs2_f;
               dec.src1   = ALU_SRC_R;
               dec.src2   = ALU_SRC_R;
               dec.alu_op = {func7[5], func3};
            end else begin
               dec.illegal = 1'b1;
            end
         end
         default: begin
            dec.illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/stage_id_buf.sv
// Buffered decode stage: DEPTH-entry instruction queue feeding a registered
// valid/ready output slot holding the decoded head instruction.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; valid never depends on ready, the producer holds its data until taken,
// and in_ready depends only on en and the queue occupancy.
module stage_id_buf
   import stage_id_buf_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int INST_W = INST_W_DEF,
   parameter int ADDR_W = INST_ADDR_W,
   parameter int DATA_W = DATA_W_DEF
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  kill,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [INST_W-1:0]     in_inst,
   input  logic [ADDR_W-1:0]     in_pc,
   output logic [REG_ADDR_W-1:0] regfile_addr1,
   output logic [REG_ADDR_W-1:0] regfile_addr2,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_reg_wr,
   output logic [REG_ADDR_W-1:0] out_reg_addr_rd,
   output logic [REG_ADDR_W-1:0] out_reg_addr_r1,
   output logic [REG_ADDR_W-1:0] out_reg_addr_r2,
   output logic [3:0]            out_alu_op,
   output logic [ALU_SRC_W-1:0]  out_alu_src_arg1,
   output logic [ALU_SRC_W-1:0]  out_alu_src_arg2,
   output logic [DATA_W-1:0]     out_imm,
   output logic                  out_is_jump,
   output logic                  out_is_branch,
   output logic                  out_is_load,
   output logic                  out_is_store,
   output logic                  out_illegal,
   output logic [2:0]            out_branch_type,
   output logic [2:0]            out_mem_size,
   output logic [ADDR_W-1:0]     out_pc
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = $clog2(DEPTH);

   // Queue storage and bookkeeping
   logic [INST_W-1:0] inst_mem_q [DEPTH];
   logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q,  count_d;

   // Output slot
   logic              out_valid_q, out_valid_d;
   dec_t              slot_dec_q,  slot_dec_d;
   logic [ADDR_W-1:0] slot_pc_q,   slot_pc_d;

   logic              push;
   logic              pop;
   logic              retire;
   logic              not_empty;
   logic [INST_W-1:0] head_inst;
   dec_t              head_dec;

   assign not_empty = (count_q != '0);
   assign head_inst = inst_mem_q[rd_ptr_q];

   inst_decoder u_dec (
      .inst (head_inst[31:0]),
      .dec  (head_dec)
   );

   // No bypass: readiness is from occupancy only, so a full queue refuses even when popping
   assign in_ready = en && (count_q < CNT_W'(DEPTH));

   assign push   = in_valid && in_ready && !kill;
   assign pop    = en && !kill && not_empty && (!out_valid_q || out_ready);
   assign retire = en && !kill && out_valid_q && out_ready && !pop;

   // Source registers of the queue head for early register-file read
   assign regfile_addr1 = not_empty ? head_dec.rs1 : '0;
   assign regfile_addr2 = not_empty ? head_dec.rs2 : '0;

   // Next-state for pointers, occupancy and the output slot; kill wins over everything
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      out_valid_d = out_valid_q;
      slot_dec_d  = slot_dec_q;
      slot_pc_d   = slot_pc_q;
      if (kill) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         count_d     = '0;
         out_valid_d = 1'b0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d    = rd_ptr_q + PTR_W'(1);
            out_valid_d = 1'b1;
            slot_dec_d  = head_dec;
            slot_pc_d   = pc_mem_q[rd_ptr_q];
         end else if (retire) begin
            out_valid_d = 1'b0;
         end
         unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Control and output-slot registers with asynchronous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         out_valid_q <= 1'b0;
         slot_dec_q  <= '0;
         slot_pc_q   <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         out_valid_q <= out_valid_d;
         slot_dec_q  <= slot_dec_d;
         slot_pc_q   <= slot_pc_d;
      end
   end

   // Queue payload storage; contents are only meaningful below count, so no reset
   always_ff @(posedge clk) begin
      if (push) begin
         inst_mem_q[wr_ptr_q] <= in_inst;
         pc_mem_q[wr_ptr_q]   <= in_pc;
      end
   end

   assign out_valid        = out_valid_q;
   assign out_reg_wr       = slot_dec_q.reg_wr;
   assign out_reg_addr_rd  = slot_dec_q.rd;
   assign out_reg_addr_r1  = slot_dec_q.rs1;
   assign out_reg_addr_r2  = slot_dec_q.rs2;
   assign out_alu_op       = slot_dec_q.alu_op;
   assign out_alu_src_arg1 = slot_dec_q.src1;
   assign out_alu_src_arg2 = slot_dec_q.src2;
   assign out_imm          = DATA_W'($signed(slot_dec_q.imm));
   assign out_is_jump      = slot_dec_q.is_jump;
   assign out_is_branch    = slot_dec_q.is_branch;
   assign out_is_load      = slot_dec_q.is_load;
   assign out_is_store     = slot_dec_q.is_store;
   assign out_illegal      = slot_dec_q.illegal;
   assign out_branch_type  = slot_dec_q.branch_type;
   assign out_mem_size     = slot_dec_q.mem_size;
   assign out_pc           = slot_pc_q;

endmodule

// File: tb/tb_stage_id_buf.sv
// Directed bench for stage_id_buf: decode table plus back-pressure, enable and kill sequences.
module tb_stage_id_buf;
   import stage_id_buf_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic        kill;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_inst;
   logic [31:0] in_pc;
   logic [4:0]  regfile_addr1;
   logic [4:0]  regfile_addr2;
   logic        out_valid;
   logic        out_ready;
   logic        out_reg_wr;
   logic [4:0]  out_reg_addr_rd;
   logic [4:0]  out_reg_addr_r1;
   logic [4:0]  out_reg_addr_r2;
   logic [3:0]  out_alu_op;
   logic [1:0]  out_alu_src_arg1;
   logic [1:0]  out_alu_src_arg2;
   logic [31:0] out_imm;
   logic        out_is_jump;
   logic        out_is_branch;
   logic        out_is_load;
   logic        out_is_store;
   logic        out_illegal;
   logic [2:0]  out_branch_type;
   logic [2:0]  out_mem_size;
   logic [31:0] out_pc;

   stage_id_buf #(.DEPTH(4)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .en               (en),
      .kill             (kill),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .in_inst          (in_inst),
      .in_pc            (in_pc),
      .regfile_addr1    (regfile_addr1),
      .regfile_addr2    (regfile_addr2),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .out_reg_wr       (out_reg_wr),
      .out_reg_addr_rd  (out_reg_addr_rd),
      .out_reg_addr_r1  (out_reg_addr_r1),
      .out_reg_addr_r2  (out_reg_addr_r2),
      .out_alu_op       (out_alu_op),
      .out_alu_src_arg1 (out_alu_src_arg1),
      .out_alu_src_arg2 (out_alu_src_arg2),
      .out_imm          (out_imm),
      .out_is_jump      (out_is_jump),
      .out_is_branch    (out_is_branch),
      .out_is_load      (out_is_load),
      .out_is_store     (out_is_store),
      .out_illegal      (out_illegal),
      .out_branch_type  (out_branch_type),
      .out_mem_size     (out_mem_size),
      .out_pc           (out_pc)
   );

   // Clock
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   localparam logic [1:0] S_R   = 2'd0;
   localparam logic [1:0] S_IMM = 2'd1;
   localparam logic [1:0] S_PC  = 2'd2;

   // One decode vector: stimulus plus hand-computed expectations
   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
      logic [15:0] regs;  // {reg_wr, rd, rs1, rs2}
      logic [18:0] ctrl;  // {alu_op, src1, src2, jump, branch, load, store, illegal, branch_type, mem_size}
      logic [31:0] imm;
      logic [9:0]  rf;    // {regfile_addr1, regfile_addr2} while queued
   } vec_t;

   vec_t vecs[13];

   logic [31:0] exp_pc_q[$];
   logic [31:0] exp_imm_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Advance one cycle; inputs are driven and outputs sampled at the falling edge
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [18:0] cf(input logic [3:0] alu, input logic [1:0] s1,
                                      input logic [1:0] s2, input logic [4:0] fl,
                                      input logic [2:0] bt, input logic [2:0] ms);
      return {alu, s1, s2, fl, bt, ms};
   endfunction

   function automatic vec_t mk(input logic [31:0] inst, input logic [31:0] pc,
                               input logic [15:0] regs, input logic [18:0] ctrl,
                               input logic [31:0] imm, input logic [9:0] rf);
      vec_t v;
      v.inst = inst; v.pc = pc; v.regs = regs; v.ctrl = ctrl; v.imm = imm; v.rf = rf;
      return v;
   endfunction

   initial begin
      int accepted;
      int seen_bad;
      int retired;
      // flags order: {jump, branch, load, store, illegal}
      vecs[0]  = mk(32'h00500093, 32'h10, {1'b1, 5'd1, 5'd0, 5'd0}, cf(4'h0, S_R,  S_IMM, 5'b00000, 3'd0, 3'd0), 32'h5,        {5'd0, 5'd0});
      vecs[1]  = mk(32'h12345137, 32'h14, {1'b1, 5'd2, 5'd0, 5'd0}, cf(4'h0, S_R,  S_IMM, 5'b00000, 3'd0, 3'd0), 32'h12345000, {5'd0, 5'd0});
      vecs[2]  = mk(32'h00512423, 32'h18, {1'b0, 5'd0, 5'd2, 5'd5}, cf(4'h0, S_R,  S_IMM, 5'b00010, 3'd0, 3'd2), 32'h8,        {5'd2, 5'd5});
      vecs[3]  = mk(32'h008000EF, 32'h1C, {1'b1, 5'd1, 5'd0, 5'd0}, cf(4'h0, S_PC, S_IMM, 5'b10000, 3'd0, 3'd0), 32'h8,        {5'd0, 5'd0});
      vecs[4]  = mk(32'h00008067, 32'h20, {1'b0, 5'd0, 5'd1, 5'd0}, cf(4'h0, S_R,  S_IMM, 5'b10000, 3'd0, 3'd0), 32'h0,        {5'd1, 5'd0});
      vecs[5]  = mk(32'hFE20CEE3, 32'h24, {1'b0, 5'd0, 5'd1, 5'd2}, cf(4'h0, S_PC, S_IMM, 5'b01000, 3'd4, 3'd0), 32'hFFFFFFFC, {5'd1, 5'd2});
      vecs[6]  = mk(32'hFF812183, 32'h28, {1'b1, 5'd3, 5'd2, 5'd0}, cf(4'h0, S_R,  S_IMM, 5'b00100, 3'd0, 3'd2), 32'hFFFFFFF8, {5'd2, 5'd0});
      vecs[7]  = mk(32'h40628233, 32'h2C, {1'b1, 5'd4, 5'd5, 5'd6}, cf(4'h8, S_R,  S_R,   5'b00000, 3'd0, 3'd0), 32'h0,        {5'd5, 5'd6});
      vecs[8]  = mk(32'h40345393, 32'h30, {1'b1, 5'd7, 5'd8, 5'd0}, cf(4'hD, S_R,  S_IMM, 5'b00000, 3'd0, 3'd0), 32'h403,      {5'd8, 5'd0});
      vecs[9]  = mk(32'h00001297, 32'h34, {1'b1, 5'd5, 5'd0, 5'd0}, cf(4'h0, S_PC, S_IMM, 5'b00000, 3'd0, 3'd0), 32'h1000,     {5'd0, 5'd0});
      vecs[10] = mk(32'hFFFFFFFF, 32'h38, {1'b0, 5'd0, 5'd0, 5'd0}, cf(4'h0, S_R,  S_R,   5'b00001, 3'd0, 3'd0), 32'h0,        {5'd0, 5'd0});
      vecs[11] = mk(32'h022081B3, 32'h3C, {1'b0, 5'd0, 5'd0, 5'd0}, cf(4'h0, S_R,  S_R,   5'b00001, 3'd0, 3'd0), 32'h0,        {5'd0, 5'd0});
      vecs[12] = mk(32'h00000013, 32'h40, {1'b0, 5'd0, 5'd0, 5'd0}, cf(4'h0, S_R,  S_IMM, 5'b00000, 3'd0, 3'd0), 32'h0,        {5'd0, 5'd0});

      // Reset
      rst_n     = 1'b0;
      en        = 1'b1;
      kill      = 1'b0;
      in_valid  = 1'b0;
      in_inst   = '0;
      in_pc     = '0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_out_imm", out_imm, 0);
      chk("reset_out_pc", out_pc, 0);
      chk("reset_in_ready", in_ready, 1);
      rst_n = 1'b1;
      step();
      en = 1'b0;
      #1 chk("en_low_in_ready", in_ready, 0);
      en = 1'b1;
      #1 chk("en_high_in_ready", in_ready, 1);

      // Decode table: push one, check early reg-file addresses, then the slot
      out_ready = 1'b1;
      for (int i = 0; i < 13; i++) begin
         in_valid = 1'b1;
         in_inst  = vecs[i].inst;
         in_pc    = vecs[i].pc;
         step();
         in_valid = 1'b0;
         chk($sformatf("v%0d_rf_addr", i), {regfile_addr1, regfile_addr2}, vecs[i].rf);
         step();
         chk($sformatf("v%0d_valid", i), out_valid, 1);
         chk($sformatf("v%0d_pc", i), out_pc, vecs[i].pc);
         chk($sformatf("v%0d_regs", i),
             {out_reg_wr, out_reg_addr_rd, out_reg_addr_r1, out_reg_addr_r2}, vecs[i].regs);
         chk($sformatf("v%0d_ctrl", i),
             {out_alu_op, out_alu_src_arg1, out_alu_src_arg2, out_is_jump, out_is_branch,
              out_is_load, out_is_store, out_illegal, out_branch_type, out_mem_size},
             vecs[i].ctrl);
         chk($sformatf("v%0d_imm", i), out_imm, vecs[i].imm);
      end
      step();
      chk("retired_idle", out_valid, 0);

      // Back-pressure: 6 offers, only 4 queued + 1 in slot fit
      out_ready = 1'b0;
      accepted  = 0;
      for (int k = 0; k < 6; k++) begin
         in_valid = 1'b1;
         in_inst  = 32'h00000093 | (k << 20);
         in_pc    = 32'h100 + 4 * k;
         if (in_ready) begin
            accepted++;
            exp_pc_q.push_back(32'h100 + 4 * k);
            exp_imm_q.push_back(k);
         end
         step();
      end
      in_valid = 1'b0;
      chk("bp_accepted", accepted, 5);
      chk("bp_in_ready_full", in_ready, 0);
      chk("bp_slot_pc", out_pc, 32'h100);

      // Enable low: slot and queue hold even with out_ready high
      en        = 1'b0;
      out_ready = 1'b1;
      #1 chk("en_low_full_in_ready", in_ready, 0);
      step();
      chk("en_low_hold_valid", out_valid, 1);
      chk("en_low_hold_pc", out_pc, 32'h100);
      en = 1'b1;

      // Drain in order
      retired = 0;
      for (int c = 0; c < 20 && exp_pc_q.size() > 0; c++) begin
         if (out_valid) begin
            chk($sformatf("drain%0d_pc", retired), out_pc, exp_pc_q.pop_front());
            chk($sformatf("drain%0d_imm", retired), out_imm, exp_imm_q.pop_front());
            retired++;
         end
         step();
      end
      chk("drain_all", exp_pc_q.size(), 0);
      chk("drain_idle", out_valid, 0);

      // Kill with 3 queued and a full slot, while fetch offers another instruction
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b1;
         in_inst  = 32'h00018113 | (k << 20);
         in_pc    = 32'h200 + 4 * k;
         step();
      end
      chk("pre_kill_valid", out_valid, 1);
      chk("pre_kill_in_ready", in_ready, 1);
      chk("pre_kill_rf1", regfile_addr1, 3);
      kill     = 1'b1;
      in_valid = 1'b1;
      in_inst  = 32'h07700493;
      in_pc    = 32'h999;
      step();
      kill     = 1'b0;
      in_valid = 1'b0;
      chk("kill_out_valid", out_valid, 0);
      chk("kill_in_ready", in_ready, 1);
      chk("kill_rf1_empty", regfile_addr1, 0);
      out_ready = 1'b1;
      seen_bad  = 0;
      for (int c = 0; c < 4; c++) begin
         step();
         if (out_valid) seen_bad++;
      end
      chk("kill_nothing_emerges", seen_bad, 0);

      // Stage works again from empty after kill
      in_valid = 1'b1;
      in_inst  = 32'h00500093;
      in_pc    = 32'h300;
      step();
      in_valid = 1'b0;
      step();
      chk("post_kill_valid", out_valid, 1);
      chk("post_kill_pc", out_pc, 32'h300);
      chk("post_kill_imm", out_imm, 5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/stage_id_buf.md
# stage_id_buf

Parametrised instruction-decode stage with a decoupling instruction queue between STAGE_FE and the execute stage. Fetched instructions are pushed into a DEPTH-entry FIFO under valid/ready. The head entry is decoded to the full RV32I integer subset (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, ALUI, ALUR) and registered into a valid/ready output slot. Unlike the previous decode stage, it:
- buffers instructions,
- applies back-pressure instead of a global stall,
- flags illegal encodings,
- supports a pipeline kill that empties the stage in one cycle.

## Interface
Parameters:
- DEPTH, 4: queue entries; power of two, ≥2.
- INST_W, `INST_W: instruction width (32).
- ADDR_W, `INST_ADDR_W: PC width.
- DATA_W, `DATA_W: immediate width (32).

Ports:
- clk  in  1  clock; all state on posedge.
- rst_n  in  1  reset; asynchronous, active-low.
- en  in  1  global enable; when low, no push, no pop, output slot holds.
- kill  in  1  synchronous pipeline redirect; empties the queue and the output slot.
- in_valid  in  1  fetch offers an instruction.
- in_ready  out  1  equals en && count < DEPTH; combinational from state only.
- in_inst  in  INST_W  instruction word.
- in_pc  in  ADDR_W  instruction address.
- regfile_addr1 / regfile_addr2  out  `REG_ADDR_W  rs1/rs2 of the queue head, combinational. Value is 0 when the queue is empty or the field is unused.
- out_valid  out  1  output slot holds a decoded instruction.
- out_ready  in  1  downstream accepts the slot this cycle.
- out_reg_wr, out_reg_addr_rd, out_reg_addr_r1, out_reg_addr_r2  out  1/`REG_ADDR_W×3  destination and source registers.
- out_alu_op  out  4  ALU operation.
- out_alu_src_arg1 / out_alu_src_arg2  out  `ALU_SRC_W  ALU operand selects.
- out_imm  out  DATA_W  sign-extended immediate.
- out_is_jump, out_is_branch, out_is_load, out_is_store, out_illegal  out  1 each  instruction class flags.
- out_branch_type  out  3  branch condition (func3).
- out_mem_size  out  3  load/store size (func3).
- out_pc  out  ADDR_W  address of the decoded instruction.

## Operation
- Push: in_valid && in_ready && !kill writes {inst, pc} at wr_ptr; wr_ptr increments.
- Pop: en && !kill && count>0 && (!out_valid || out_ready). The head is decoded into the output slot, out_valid is set, and rd_ptr increments.
- Retire: out_valid && out_ready with no pop clears out_valid.
- Push and pop in the same cycle leave count unchanged. There is no bypass: a full queue deasserts in_ready even if a pop occurs that cycle.
- Output fields are stable while out_valid && !out_ready.
- kill has priority over push, pop and retire:
  - count, wr_ptr and rd_ptr go to 0 and out_valid goes to 0;
  - in_valid is ignored that cycle;
  - decode fields are don't-care.
- Decode per opcode:
  - LUI: rs1=0, arg1=R, arg2=IMM, imm={U,12'b0}.
  - AUIPC: rs1=0, arg1=PC, arg2=IMM, imm={U,12'b0}.
  - JAL: rs1=0, arg1=PC, arg2=IMM, imm=sext J<<1, is_jump.
  - JALR: arg1=R, arg2=IMM, imm=sext I, is_jump.
  - BRANCH: arg1=PC, arg2=IMM, imm=sext B<<1, is_branch, branch_type=func3.
  - LOAD: arg1=R, arg2=IMM, imm=sext I, is_load, mem_size=func3.
  - STORE: arg1=R, arg2=IMM, imm=sext S, is_store, mem_size=func3.
  - ALUI: imm=sext I, alu_op={0,func3}. Exception: for func3=101, alu_op={inst[30],func3}.
  - ALUR: arg2=R, alu_op={func7[5],func3}. func7 must be `func7_ALU_0 or `func7_ALU_1.
  - All classes other than ALUI/ALUR use alu_op=`ALU_OP_ADD.
- rs2 is forced to 0 unless the class is ALUR, BRANCH or STORE. This prevents false hazards.
- reg_wr = (LUI|AUIPC|JAL|JALR|LOAD|ALUI|ALUR) && rd≠0.
- Illegal: any other opcode, or ALUR with a bad func7. Sets out_illegal=1 and reg_wr=0; all class flags are 0.
- count is $clog2(DEPTH+1) bits. Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.

## Timing
- Reset (rst_n low, asynchronous):
  - count, pointers and out_valid are 0; every out_* field is 0;
  - in_ready is 1 once en=1.
- Latency: an instruction pushed at edge E is popped at the earliest at edge E+1, so out_valid=1 after E+1. Sustained throughput is 1 instruction/cycle with out_ready held high.
- Capacity: DEPTH queued plus 1 in the output slot.
- en low: all state holds, in_ready=0, and out_valid is unchanged.
- kill and reset take effect at the same edge/instant; in_ready=1 on the following cycle.

## Structure
- All opcode, func7, ALU_OP_*, ALU_SRC_* and width constants live in defines.vh. Add OPCODE_AUIPC, OPCODE_JAL, OPCODE_LOAD and OPCODE_STORE there.
- One sub-module: inst_decoder, purely combinational (inst → decode bundle).
- The FIFO and the output slot are inline in stage_id_buf.

## Test plan
- After reset, push addi x1,x0,5 (0x00500093) at pc 0x10 with out_ready=1:
  - one cycle later, out_valid=1, rd=1, rs1=0, imm=5, alu_op=ADD, arg2=IMM, reg_wr=1, out_pc=0x10.
- lui x2,0x12345 (0x12345137):
  - imm=0x12345000, out_reg_addr_r1=0, regfile_addr1=0, reg_wr=1.
- sw x5,8(x2) (0x00512423):
  - is_store=1, mem_size=010, rs1=2, rs2=5, imm=8, reg_wr=0.
- Back-pressure with DEPTH=4 and out_ready=0, pushing 6 instructions:
  - 5 are accepted and in_ready=0 after the 5th;
  - on release, order and PCs are preserved.
- Queue at 3 entries with out_valid=1, then assert kill together with in_valid:
  - next cycle, count=0, out_valid=0, in_ready=1;
  - the killed-cycle instruction never appears.
- 0xFFFFFFFF, then add with func7=0x01:
  - both produce out_illegal=1, reg_wr=0 and all class flags 0.
